ddr_axi_memtest: RTL
====================

DDR_AXI_MEMTEST -- requirements
Module: ddr_axi_memtest

Interface
REQ-001 Parameter BASE_ADDR, default 28'h0000000, byte address of the first burst; SHALL be aligned to BURST_LEN*4.
REQ-002 Parameter BURST_LEN, default 16, beats per burst, range 1..256; BURST_LEN*4 SHALL divide 4096.
REQ-003 Parameter NUM_BURSTS, default 64, bursts per pass, range 1..65535.
REQ-004 Parameter SEED, default 32'hA5A5_0000, data pattern seed.
REQ-005 sys_clk  in  1  single clock; all logic rising-edge.
REQ-006 sys_rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  single-cycle request to run one write+read pass.
REQ-008 busy, done, pass  out  1 each  status; done is a 1-cycle pulse; pass is held until next start.
REQ-009 err_count  out  16  mismatch/response error count for the current pass.
REQ-010 fail_addr  out  28  and  fail_data  out  32: first failing beat address and read data.
REQ-011 AXI4 master ports ddr_aw*/ddr_w*/ddr_b*/ddr_ar*/ddr_r*: 4-bit IDs, 28-bit address, 32-bit data, 4-bit wstrb, 8-bit len; directions opposite to the DDR slave side.

Function
REQ-012 Constants: awid/arid 0, awsize/arsize 3'b010, awburst/arburst 2'b01 (INCR), awcache/arcache 4'b0011, awprot/arprot 0, awqos/arqos 0, wstrb 4'hF, awlen/arlen BURST_LEN-1.
REQ-013 FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-014 IDLE: start=1 -> WR_ADDR; burst index, beat index, err_count, fail_addr and fail_data cleared; pass cleared. Start while busy is ignored.
REQ-015 Burst b address = BASE_ADDR + b*BURST_LEN*4, computed modulo 2^28.
REQ-016 WR_ADDR: awvalid=1 with address stable until awready; handshake -> WR_DATA.
REQ-017 WR_DATA: wvalid=1; beat k data = {4'h0, addr_k} XOR SEED with addr_k = burst address + 4k; wlast=1 only on beat BURST_LEN-1; data and wlast held while wready=0; last handshake -> WR_RESP.
REQ-018 WR_RESP: bready=1; on bvalid, bresp!=2'b00 increments err_count; next WR_ADDR or, after burst NUM_BURSTS-1, RD_ADDR with burst index reset to 0.
REQ-019 Exactly one transaction outstanding; awvalid and wvalid are never asserted together.
REQ-020 RD_ADDR: arvalid=1 held until arready -> RD_DATA.
REQ-021 RD_DATA: rready=1; each beat compared to the REQ-017 pattern; an error is counted once per beat if rdata differs, rresp!=2'b00, or rlast differs from (beat==BURST_LEN-1).
REQ-022 On the burst's final beat (beat counter reaching BURST_LEN-1), next RD_ADDR, or DONE after burst NUM_BURSTS-1; a premature rlast does not end the burst.
REQ-023 DONE: done=1 for one cycle; pass=(err_count==0); return to IDLE next cycle.
REQ-024 err_count saturates at 16'hFFFF.
REQ-025 busy=1 in every state except IDLE.
REQ-026 All AXI valid/ready outputs are registered; no combinational path from AXI inputs to AXI outputs.

Reset
REQ-027 sys_rst=1 forces IDLE and drives all valid/ready/last outputs, busy, done, pass, err_count, fail_addr and fail_data to 0 on the next edge.
REQ-028 Reset mid-transaction abandons it immediately; the DDR slave shares sys_rst, so no completion is awaited.

Configuration
REQ-029 Macro DDR_MEMTEST_FAIL_CAPTURE_EN defined: fail_addr/fail_data capture the address and rdata of the first beat that increments err_count from 0 and hold them until next start.
REQ-030 Macro undefined: no capture registers; fail_addr and fail_data are constant 0; all other behaviour is identical.

Verification (BASE_ADDR=0, BURST_LEN=4, NUM_BURSTS=2, SEED=32'hA5A5_0000)
REQ-031 Ideal zero-wait slave, start pulse -> awaddr 0x00, 0x10; wdata beats 0xA5A50000, 0xA5A50004, 0xA5A50008, 0xA5A5000C; done pulse, pass=1, err_count=0.
REQ-032 Slave corrupts read beat at addr 0x14 to 0 -> err_count=1, pass=0; with macro fail_addr=0x14, fail_data=0; without macro both 0.
REQ-033 Random ready/valid stalls on every channel -> payloads held stable while stalled, identical result to REQ-031, awvalid and wvalid never high together.
REQ-034 bresp=2'b10 on the first write burst and rresp=2'b10 on one read beat -> err_count=2.
REQ-035 sys_rst asserted during WR_DATA beat 2 -> next cycle all outputs 0, state IDLE; a new start runs to pass=1.
REQ-036 start pulsed again while busy -> ignored; exactly 2 AW and 2 AR handshakes, one done pulse.

Source files
------------

// File: rtl/ddr_axi_memtest.sv
// ddr_axi_memtest: AXI4 write-then-read-back memory tester.
// One pass writes NUM_BURSTS INCR bursts of an address-derived pattern starting at BASE_ADDR,
// reads them back, compares every beat and reports an error count and pass/fail.
// Optional macro DDR_MEMTEST_FAIL_CAPTURE_EN enables first-failure address/data capture;
// without it fail_addr and fail_data are tied to zero.
module ddr_axi_memtest #(
    parameter logic [27:0] BASE_ADDR  = 28'h0000000,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned NUM_BURSTS = 64,
    parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [27:0] fail_addr,
    output logic [31:0] fail_data,
    // write address channel
    output logic [3:0]  ddr_awid,
    output logic [27:0] ddr_awaddr,
    output logic [7:0]  ddr_awlen,
    output logic [2:0]  ddr_awsize,
    output logic [1:0]  ddr_awburst,
    output logic [3:0]  ddr_awcache,
    output logic [2:0]  ddr_awprot,
    output logic [3:0]  ddr_awqos,
    output logic        ddr_awvalid,
    input  logic        ddr_awready,
    // write data channel
    output logic [31:0] ddr_wdata,
    output logic [3:0]  ddr_wstrb,
    output logic        ddr_wlast,
    output logic        ddr_wvalid,
    input  logic        ddr_wready,
    // write response channel
    input  logic [3:0]  ddr_bid,
    input  logic [1:0]  ddr_bresp,
    input  logic        ddr_bvalid,
    output logic        ddr_bready,
    // read address channel
    output logic [3:0]  ddr_arid,
    output logic [27:0] ddr_araddr,
    output logic [7:0]  ddr_arlen,
    output logic [2:0]  ddr_arsize,
    output logic [1:0]  ddr_arburst,
    output logic [3:0]  ddr_arcache,
    output logic [2:0]  ddr_arprot,
    output logic [3:0]  ddr_arqos,
    output logic        ddr_arvalid,
    input  logic        ddr_arready,
    // read data channel
    input  logic [3:0]  ddr_rid,
    input  logic [31:0] ddr_rdata,
    input  logic [1:0]  ddr_rresp,
    input  logic        ddr_rlast,
    input  logic        ddr_rvalid,
    output logic        ddr_rready
);

    localparam int unsigned BurstBytes = BURST_LEN * 4;
    localparam logic [7:0]  LastBeat   = 8'(BURST_LEN - 1);
    localparam logic [15:0] LastBurst  = 16'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [15:0] burst_q, burst_d;
    logic [7:0]  beat_q, beat_d;
    logic [15:0] err_q, err_d;
    logic        pass_q, pass_d;

    // Registered handshake/status outputs, decoded from the next state
    logic awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d;
    logic wlast_q, wlast_d;
    logic bready_q, bready_d;
    logic arvalid_q, arvalid_d;
    logic rready_q, rready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic        err_inc;
    logic        enter_done;
    logic        fail_cap;
    logic        fail_clr;

    logic [27:0] burst_addr;
    logic [27:0] beat_addr;
    logic [31:0] exp_data;
    logic        rd_err;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Address and pattern of the current beat; wraps modulo 2^28
    assign burst_addr = BASE_ADDR + 28'(burst_q) * 28'(BurstBytes);
    assign beat_addr  = burst_addr + {18'b0, beat_q, 2'b00};
    assign exp_data   = {4'h0, beat_addr} ^ SEED;

    assign aw_hs = awvalid_q & ddr_awready;
    assign w_hs  = wvalid_q & ddr_wready;
    assign b_hs  = bready_q & ddr_bvalid;
    assign ar_hs = arvalid_q & ddr_arready;
    assign r_hs  = rready_q & ddr_rvalid;

    // A read beat is bad if data, response or last flag disagree; counted once per beat
    assign rd_err = (ddr_rdata != exp_data) || (ddr_rresp != 2'b00) ||
                    (ddr_rlast != (beat_q == LastBeat));

    // State register plus all counters and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and counter update logic
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        err_d      = err_q;
        pass_d     = pass_q;
        err_inc    = 1'b0;
        enter_done = 1'b0;
        fail_cap   = 1'b0;
        fail_clr   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StWrAddr;
                    burst_d  = '0;
                    beat_d   = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                    fail_clr = 1'b1;
                end
            end
            StWrAddr: begin
                if (aw_hs) state_d = StWrData;
            end
            StWrData: begin
                if (w_hs) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StWrResp;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StWrResp: begin
                if (b_hs) begin
                    err_inc = (ddr_bresp != 2'b00);
                    if (burst_q == LastBurst) begin
                        burst_d = '0;
                        state_d = StRdAddr;
                    end else begin
                        burst_d = burst_q + 16'd1;
                        state_d = StWrAddr;
                    end
                end
            end
            StRdAddr: begin
                if (ar_hs) state_d = StRdData;
            end
            StRdData: begin
                if (r_hs) begin
                    err_inc  = rd_err;
                    fail_cap = rd_err && (err_q == '0);
                    // Only the beat counter ends a burst; an early rlast is just an error
                    if (beat_q == LastBeat) begin
                        beat_d = '0;
                        if (burst_q == LastBurst) begin
                            burst_d    = '0;
                            state_d    = StDone;
                            enter_done = 1'b1;
                        end else begin
                            burst_d = burst_q + 16'd1;
                            state_d = StRdAddr;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (err_inc && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
        // pass is valid in the same cycle as the done pulse
        if (enter_done) pass_d = (err_d == '0);
    end

    // Output decode: next values of the registered AXI valid/ready and status flags
    always_comb begin
        awvalid_d = (state_d == StWrAddr);
        wvalid_d  = (state_d == StWrData);
        wlast_d   = (state_d == StWrData) && (beat_d == LastBeat);
        bready_d  = (state_d == StWrResp);
        arvalid_d = (state_d == StRdAddr);
        rready_d  = (state_d == StRdData);
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

`ifdef DDR_MEMTEST_FAIL_CAPTURE_EN
    logic [27:0] fail_addr_q;
    logic [31:0] fail_data_q;

    // Hold address and read data of the first beat that took err_count off zero
    always_ff @(posedge sys_clk) begin
        if (sys_rst || fail_clr) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (fail_cap) begin
            fail_addr_q <= beat_addr;
            fail_data_q <= ddr_rdata;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`else
    logic unused_fail;
    assign unused_fail = fail_cap ^ fail_clr;
    assign fail_addr   = '0;
    assign fail_data   = '0;
`endif

    // Single outstanding transaction, so response IDs carry no information
    logic unused_ids;
    assign unused_ids = ^{ddr_bid, ddr_rid};

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

    assign ddr_awid    = 4'h0;
    assign ddr_awaddr  = burst_addr;
    assign ddr_awlen   = LastBeat;
    assign ddr_awsize  = 3'b010;
    assign ddr_awburst = 2'b01;
    assign ddr_awcache = 4'b0011;
    assign ddr_awprot  = 3'b000;
    assign ddr_awqos   = 4'h0;
    assign ddr_awvalid = awvalid_q;

    assign ddr_wdata  = exp_data;
    assign ddr_wstrb  = 4'hF;
    assign ddr_wlast  = wlast_q;
    assign ddr_wvalid = wvalid_q;

    assign ddr_bready = bready_q;

    assign ddr_arid    = 4'h0;
    assign ddr_araddr  = burst_addr;
    assign ddr_arlen   = LastBeat;
    assign ddr_arsize  = 3'b010;
    assign ddr_arburst = 2'b01;
    assign ddr_arcache = 4'b0011;
    assign ddr_arprot  = 3'b000;
    assign ddr_arqos   = 4'h0;
    assign ddr_arvalid = arvalid_q;

    assign ddr_rready = rready_q;

endmodule
